// File: rtl/prescaler_switch_ctrl_if.sv
// Requester-side bundle of the prescaler switch controller: two level requests,
// their requested selects and the per-requester completion pulse.
interface prescaler_switch_ctrl_if #(
    parameter int unsigned SEL_W = 2
);
    logic [1:0]         req_i;
    logic [2*SEL_W-1:0] sel_i;
    logic [1:0]         ack_o;

    modport master (output req_i, output sel_i, input ack_o);
    modport slave  (input req_i, input sel_i, output ack_o);
endinterface

// File: rtl/prescaler_switch_ctrl.sv
// Shares the system clock prescaler select/enable between two requesters using a
// drain -> switch -> settle -> ack sequence. Optional: PRESCALER_SWITCH_RR_EN (round-robin).
module prescaler_switch_ctrl #(
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned RESET_SEL     = 0,
    parameter int unsigned DRAIN_CYCLES  = 64,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    prescaler_switch_ctrl_if.slave req_bus,
    output logic                   clk_en_o,
    output logic [SEL_W-1:0]       prescaler_sel_o,
    output logic                   busy_o
);
    localparam int unsigned MAX_CYC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SWITCH,
        ST_SETTLE,
        ST_ACK
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_grant;
    logic               w_grant_nxt;
    logic [SEL_W-1:0]   r_sel_lat;
    logic [SEL_W-1:0]   w_sel_lat_nxt;
    logic [SEL_W-1:0]   r_sel_out;
    logic [SEL_W-1:0]   w_sel_out_nxt;
    logic               r_clk_en;
    logic               w_clk_en_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic [1:0]         r_ack;
    logic [1:0]         w_ack_nxt;
    logic [1:0]         w_req;
    logic               w_arb_idx;
    logic [SEL_W-1:0]   w_arb_sel;

    assign w_req = req_bus.req_i;

    // Arbitration: pick the winning requester among the currently raised requests.
`ifdef PRESCALER_SWITCH_RR_EN
    logic r_ptr;

    assign w_arb_idx = (w_req == 2'b11) ? r_ptr : ~w_req[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (r_state == ST_IDLE && |w_req) begin
            r_ptr <= ~w_arb_idx;
        end
    end
`else
    assign w_arb_idx = ~w_req[0];
`endif

    assign w_arb_sel = w_arb_idx ? req_bus.sel_i[2*SEL_W-1:SEL_W] : req_bus.sel_i[SEL_W-1:0];

    // Next-state, counter and registered-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_sel_lat_nxt = r_sel_lat;
        w_sel_out_nxt = r_sel_out;

        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_grant_nxt   = w_arb_idx;
                    w_sel_lat_nxt = w_arb_sel;
                    if (w_arb_sel == r_sel_out) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_SWITCH;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                w_sel_out_nxt = r_sel_lat;
                w_state_nxt   = ST_SETTLE;
                w_cnt_nxt     = CNT_W'(SETTLE_CYCLES - 1);
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_clk_en_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_ACK);
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_ack_nxt    = 2'b00;
        if (w_state_nxt == ST_ACK) begin
            w_ack_nxt = w_grant_nxt ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_grant   <= 1'b0;
            r_sel_lat <= SEL_W'(RESET_SEL);
            r_sel_out <= SEL_W'(RESET_SEL);
            r_clk_en  <= 1'b1;
            r_busy    <= 1'b0;
            r_ack     <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_sel_lat <= w_sel_lat_nxt;
            r_sel_out <= w_sel_out_nxt;
            r_clk_en  <= w_clk_en_nxt;
            r_busy    <= w_busy_nxt;
            r_ack     <= w_ack_nxt;
        end
    end

    assign req_bus.ack_o   = r_ack;
    assign clk_en_o        = r_clk_en;
    assign prescaler_sel_o = r_sel_out;
    assign busy_o          = r_busy;
endmodule

// File: tb/tb_prescaler_switch_ctrl.sv
// Randomized self-checking bench for prescaler_switch_ctrl against a transaction-level
// timing model; honours PRESCALER_SWITCH_RR_EN for the arbitration rule.
module tb_prescaler_switch_ctrl;
    localparam int unsigned SEL_W     = 2;
    localparam int unsigned RESET_SEL = 0;
    localparam int unsigned D         = 64;
    localparam int unsigned S         = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic             busy;
    logic [SEL_W-1:0] psel;
    logic [1:0]       req_drv;
    logic [SEL_W-1:0] sel_drv [2];

    int n_checks = 0;
    int n_fail   = 0;
    int m_sel;
    int m_ptr;

    always #5 clk = ~clk;

    prescaler_switch_ctrl_if #(.SEL_W(SEL_W)) bus ();

    assign bus.req_i = req_drv;
    assign bus.sel_i = {sel_drv[1], sel_drv[0]};

    prescaler_switch_ctrl #(
        .SEL_W         (SEL_W),
        .RESET_SEL     (RESET_SEL),
        .DRAIN_CYCLES  (D),
        .SETTLE_CYCLES (S)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .req_bus         (bus),
        .clk_en_o        (clk_en),
        .prescaler_sel_o (psel),
        .busy_o          (busy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input int en, input int sel, input int ack, input int bsy);
        check_eq($sformatf("%s.clk_en", tag), int'(clk_en), en);
        check_eq($sformatf("%s.sel", tag), int'(psel), sel);
        check_eq($sformatf("%s.ack", tag), int'(bus.ack_o), ack);
        check_eq($sformatf("%s.busy", tag), int'(busy), bsy);
    endtask

    function automatic int arb(input logic [1:0] req);
        if (req == 2'b11) begin
`ifdef PRESCALER_SWITCH_RR_EN
            return m_ptr;
`else
            return 0;
`endif
        end
        return req[0] ? 0 : 1;
    endfunction

    // One granted request from the IDLE cycle in which it is sampled (cycle 0) to the IDLE after ack.
    task automatic run_txn(input int wd_cyc, input int raise_cyc, input int rst_cyc);
        int g;
        int new_sel;
        int len;
        int exp_en;
        int exp_sel;
        bit shortcut;
        g        = arb(req_drv);
        new_sel  = int'(sel_drv[g]);
        shortcut = (new_sel == m_sel);
        len      = shortcut ? 1 : int'(D + S + 2);
`ifdef PRESCALER_SWITCH_RR_EN
        m_ptr = 1 - g;
`endif
        for (int k = 1; k <= len; k++) begin
            tick();
            exp_en  = (!shortcut && k <= int'(D) + 1) ? 0 : 1;
            exp_sel = (!shortcut && k >= int'(D) + 2) ? new_sel : m_sel;
            check_outputs($sformatf("txn_g%0d_k%0d", g, k), exp_en, exp_sel, (k == len) ? (1 << g) : 0, 1);
            if (k == rst_cyc) begin
                rst     = 1'b1;
                req_drv = 2'b00;
                tick();
                rst   = 1'b0;
                m_sel = RESET_SEL;
                m_ptr = 0;
                check_outputs("rst_mid", 1, m_sel, 0, 0);
                for (int j = 0; j < len; j++) begin
                    tick();
                    check_outputs("post_rst", 1, m_sel, 0, 0);
                end
                return;
            end
            if (k == wd_cyc) begin
                req_drv[g] = 1'b0;
                sel_drv[g] = SEL_W'($urandom);
            end
            if (k == raise_cyc && !req_drv[1-g]) begin
                req_drv[1-g] = 1'b1;
                sel_drv[1-g] = SEL_W'($urandom);
            end
        end
        req_drv[g] = 1'b0;
        m_sel      = new_sel;
        tick();
        check_outputs("idle_after", 1, m_sel, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        req_drv    = 2'b00;
        sel_drv[0] = '0;
        sel_drv[1] = '0;
        m_sel      = RESET_SEL;
        m_ptr      = 0;

        tick();
        tick();
        check_outputs("reset", 1, RESET_SEL, 0, 0);
        rst = 1'b0;
        tick();
        check_outputs("idle0", 1, RESET_SEL, 0, 0);

        // Single full switch 0 -> 3 by requester 0.
        sel_drv[0] = SEL_W'(3);
        req_drv    = 2'b01;
        run_txn(0, 0, 0);

        // Shortcut: requester 1 asks for the select already applied.
        sel_drv[1] = SEL_W'(3);
        req_drv    = 2'b10;
        run_txn(0, 0, 0);

        // Simultaneous requests, twice.
        sel_drv[0] = SEL_W'(1);
        sel_drv[1] = SEL_W'(2);
        req_drv    = 2'b11;
        run_txn(0, 0, 0);
        run_txn(0, 0, 0);
        sel_drv[0] = SEL_W'(0);
        sel_drv[1] = SEL_W'(3);
        req_drv    = 2'b11;
        run_txn(0, 0, 0);
        run_txn(0, 0, 0);

        // Reset during DRAIN abandons the sequence.
        sel_drv[0] = SEL_W'(2);
        req_drv    = 2'b01;
        run_txn(0, 0, 30);

        // Request withdrawn and select changed mid-sequence.
        sel_drv[0] = SEL_W'(1);
        req_drv    = 2'b01;
        run_txn(10, 0, 0);

        for (int it = 0; it < 40; it++) begin
            if (req_drv == 2'b00 && $urandom_range(0, 3) == 0) begin
                tick();
                check_outputs("rand_idle", 1, m_sel, 0, 0);
                continue;
            end
            for (int r = 0; r < 2; r++) begin
                if (!req_drv[r] && $urandom_range(0, 1) == 1) begin
                    req_drv[r] = 1'b1;
                    sel_drv[r] = SEL_W'($urandom);
                end
            end
            if (req_drv == 2'b00) begin
                req_drv[0] = 1'b1;
                sel_drv[0] = SEL_W'($urandom);
            end
            run_txn(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 70)) : 0,
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0,
                    0);
        end
        while (req_drv != 2'b00) begin
            run_txn(0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prescaler_switch_ctrl.md
# prescaler_switch_ctrl

Controller that owns the select and enable inputs of the system clock prescaler and shares them between two requesters, e.g. software config and the power manager. Each accepted request runs a fixed safe-switch sequence: disable and drain the divider, apply the new prescaler select, re-enable, let it settle, then acknowledge. Outputs connect directly to the prescaler's `enable` and `prescaler_sel` inputs.

## Interface
- `SEL_W`, 2: prescaler select width.
- `RESET_SEL`, 0: select value applied at reset.
- `DRAIN_CYCLES`, 64: cycles `clk_en_o` is held low before switching. Must be ≥1 and ≥ the largest prescaler ratio.
- `SETTLE_CYCLES`, 4: cycles after re-enable before ack. Must be ≥1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req_i`  in  2  per-requester level request; held until ack.
- `sel_i`  in  2×SEL_W  requested select, `sel_i[r*SEL_W +: SEL_W]`; stable while `req_i[r]` is high.
- `ack_i`… none; `ack_o`  out  2  one-cycle completion pulse to the granted requester.
- `clk_en_o`  out  1  prescaler enable.
- `prescaler_sel_o`  out  SEL_W  prescaler select.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DRAIN, SWITCH, SETTLE, ACK. All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- **IDLE**
  - If any `req_i` bit is set, arbitrate and latch the grant index `g` and `sel_i` of `g`.
  - If the latched select equals `prescaler_sel_o`, go to ACK (shortcut). Otherwise go to DRAIN.
- **DRAIN**
  - `clk_en_o`=0. A down-counter loaded with DRAIN_CYCLES-1 counts to 0, then the state goes to SWITCH.
- **SWITCH**
  - One cycle. `clk_en_o`=0. `prescaler_sel_o` loads the latched select on exit. Next state is SETTLE.
- **SETTLE**
  - `clk_en_o`=1. The counter is loaded with SETTLE_CYCLES-1 and counts to 0, then the state goes to ACK.
- **ACK**
  - `ack_o[g]`=1 for exactly one cycle. Next state is IDLE.
- `clk_en_o`=1 in IDLE, SETTLE and ACK.
- Requester rule: drop `req_i[r]` in the cycle after `ack_o[r]`.
  - A requester that violates this is served again, through the shortcut path, in 2 cycles.
- Changes to `sel_i` or `req_i` after the grant are ignored until IDLE.
  - A request withdrawn mid-sequence still completes, and its ack is still pulsed.
- Non-granted requests wait; they are never dropped.
- Counter width: `$clog2(max(DRAIN_CYCLES,SETTLE_CYCLES))`, minimum 1. The counter never wraps.

## Timing
- Reset values (take effect on the first `clk` edge with `rst`=1):
  - state=IDLE, `clk_en_o`=1, `prescaler_sel_o`=RESET_SEL, `ack_o`=0, `busy_o`=0, counter=0.
  - Round-robin pointer favours requester 0.
- Reset mid-sequence: the sequence is abandoned and no ack is issued. The reset values above apply the next cycle, including `prescaler_sel_o`=RESET_SEL.
- With the request sampled in IDLE at cycle 0, D=DRAIN_CYCLES and S=SETTLE_CYCLES:
  - DRAIN: cycles 1..D.
  - SWITCH: cycle D+1.
  - New `prescaler_sel_o` visible: cycle D+2.
  - SETTLE: cycles D+2..D+S+1.
  - `ack_o`: cycle D+S+2.
- Defaults give ack at cycle 70.
- Shortcut path: ack at cycle 1, with no `clk_en_o` dip.
- Back-to-back: the earliest next grant is in the IDLE cycle after ACK.
- `prescaler_sel_o` only changes while `clk_en_o` has been 0 for ≥D cycles.

## Configuration
- `PRESCALER_SWITCH_RR_EN`
  - **Defined:** round-robin arbitration. A one-bit pointer flips to the non-granted requester after each grant, and the pointer requester wins a simultaneous request.
  - **Undefined:** fixed priority; requester 0 always wins, and the pointer logic is not built.

## Test plan
- **Reset:** `rst`=1 for 2 cycles → `clk_en_o`=1, `prescaler_sel_o`=0, `ack_o`=0, `busy_o`=0.
- **Single switch:** `req_i`=01, sel 0→3, defaults.
  - `clk_en_o` low for cycles 1..65.
  - `prescaler_sel_o`=3 from cycle 66.
  - `ack_o`=01 at cycle 70 only.
- **Shortcut:** `req_i`=10 with sel equal to current → `ack_o`=10 at cycle 1, `clk_en_o` stays 1.
- **Simultaneous requests:** `req_i`=11 twice.
  - RR_EN defined: grants 0 then 1; a new 11 is then granted to 0.
  - RR_EN undefined: requester 0 is always granted first.
- **Reset mid-sequence:** `rst` asserted at cycle 30 of DRAIN → no ack; the next cycle shows IDLE, `clk_en_o`=1, sel=RESET_SEL.
- **Withdrawn and changing request:** `req_i` dropped and `sel_i` changed at cycle 10 → the originally latched sel is applied and ack is still pulsed at cycle 70.
